axil_wr_slave_mux: RTL and testbench
====================================

Name: axil_wr_slave_mux

Overview:
- Per-slave AXI4-Lite write-path multiplexer, one instance per crossbar slave port.
- Sits directly around the round-robin arbiter: presents master AW requests to it, takes its one-hot grant, and locks the winner for the whole AW/W/B transaction.
- Forwards the winner's AW and W to the slave and routes B back to that master only.
- Pulses the arbiter acknowledge on B completion so the arbiter rotates priority.

Parameters:
- N_MST, 4, number of masters.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_awvalid  in  N_MST  per-master AW valid
- s_awaddr  in  N_MST*ADDR_W  per-master AW address; master i at bits [i*ADDR_W +: ADDR_W]
- s_awready  out  N_MST  per-master AW ready
- s_wvalid  in  N_MST  per-master W valid
- s_wdata  in  N_MST*DATA_W  per-master write data, packed as above
- s_wstrb  in  N_MST*DATA_W/8  per-master strobes, packed as above
- s_wready  out  N_MST  per-master W ready
- s_bvalid  out  N_MST  per-master B valid
- s_bresp  out  2  B response, broadcast to all masters; only meaningful with s_bvalid
- s_bready  in  N_MST  per-master B ready
- m_awvalid, m_awaddr, m_awready  out/out/in  1/ADDR_W/1  slave AW channel
- m_wvalid, m_wdata, m_wstrb, m_wready  out/out/out/in  1/DATA_W/DATA_W/8/1  slave W channel
- m_bvalid, m_bresp, m_bready  in/in/out  1/2/1  slave B channel
- arb_req_o  out  N_MST  request vector to arbiter
- arb_grant_i  in  N_MST  one-hot grant from arbiter, combinational in arb_req_o
- arb_ack_o  out  1  transaction-complete pulse to arbiter

Behaviour:
- State machine has three states:
  - IDLE.
  - XFER: AW and W forwarding.
  - RESP: wait for B.
- Registers: state, sel_q (one-hot locked master), aw_done_q, w_done_q.
- Reset values: state=IDLE, sel_q=0, done flags=0.
  - In reset and in IDLE, every ready/valid output is 0: s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready.
  - arb_ack_o=0.
  - m_awaddr, m_wdata, m_wstrb are don't-care.
- arb_req_o:
  - Equals s_awvalid in IDLE.
  - Equals sel_q in XFER and RESP, so the arbiter grant stays stable and its mask update uses the locked master.
- IDLE:
  - If |s_awvalid and arb_grant_i is nonzero: sel_q <= arb_grant_i; enter XFER next cycle. Forwarding starts one cycle after request.
  - If |s_awvalid but the grant is zero: stay in IDLE (arbiter fault).
- XFER, with k = index of sel_q (one-hot to binary):
  - AW path, while !aw_done_q: m_awvalid=s_awvalid[k], m_awaddr=master k slice, s_awready[k]=m_awready.
  - W path, while !w_done_q: m_wvalid=s_wvalid[k], wdata/wstrb from master k, s_wready[k]=m_wready.
  - AW and W are independent and may complete in either order or the same cycle. Each sets its done flag on handshake.
  - Once a channel's flag is set, that channel's valid and ready are 0.
  - Exit to RESP on the cycle after both handshakes have occurred. Flags clear on exit.
- RESP:
  - s_bvalid[k]=m_bvalid, m_bready=s_bready[k], s_bresp=m_bresp.
  - On B handshake: arb_ack_o=1 for exactly that cycle (combinational); state <= IDLE.
- Non-selected masters always see ready=0 and bvalid=0, whatever their valids.
- A master whose AW or W arrives mid-transaction waits. Its valid stays pending and it competes in the next IDLE.
- Minimum transaction: IDLE -> XFER -> RESP -> IDLE, 3 cycles. Next grant no earlier than 1 cycle after B handshake.
- Reset mid-transaction: return to IDLE immediately and drop the transaction. No ack is issued.
- Slave stalls (m_awready/m_wready/m_bready paths held low): the state holds indefinitely. No timeout.
- Every valid output is derived only from valids and state, never from the matching ready (AXI rule).

Test Plan:
- Single master: s_awvalid=4'b0010, grant=4'b0010, addr 0x100, data 0xDEADBEEF, strb 0xF.
  - Required: m_awaddr=0x100 and m_wdata=0xDEADBEEF one cycle later.
  - Required: B OKAY reaches master 1 only; arb_ack_o pulses exactly once.
- Contention: masters 0 and 2 request together; grant=4'b0001.
  - Required: master 2 sees s_awready[2]=0 throughout.
  - Required: after master 0's B, IDLE presents 4'b0100 and master 2 is served next.
- W before AW: W handshake in cycle 1, AW delayed until m_awready rises in cycle 4.
  - Required: enter RESP in cycle 5; no second W handshake.
- Slave backpressure: m_bvalid held 5 cycles with s_bready[k]=0.
  - Required: m_bready=0, state stays RESP, arb_ack_o=0.
  - Required: on s_bready=1, ack pulses and IDLE follows.
- Reset mid-transaction: assert rst_n=0 in XFER after AW handshake.
  - Required: all valid/ready outputs 0 in the same cycle; arb_ack_o never asserted.
  - Required: next transaction is clean.
- Back-to-back: all four masters request continuously, grants rotate 0-1-2-3.
  - Required: four complete transactions, each ack aligned to its B handshake.

Source files
------------

// File: rtl/axil_wr_slave_mux_if.sv
// Write-path bundle around one crossbar slave port: master-facing AW/W/B vectors,
// the slave-facing AW/W/B channel and the arbiter request/grant/ack handshake.
interface axil_wr_slave_mux_if #(
  parameter int N_MST  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [N_MST-1:0]        s_awvalid;
  logic [N_MST*ADDR_W-1:0] s_awaddr;
  logic [N_MST-1:0]        s_awready;
  logic [N_MST-1:0]        s_wvalid;
  logic [N_MST*DATA_W-1:0] s_wdata;
  logic [N_MST*STRB_W-1:0] s_wstrb;
  logic [N_MST-1:0]        s_wready;
  logic [N_MST-1:0]        s_bvalid;
  logic [1:0]              s_bresp;
  logic [N_MST-1:0]        s_bready;

  logic                    m_awvalid;
  logic [ADDR_W-1:0]       m_awaddr;
  logic                    m_awready;
  logic                    m_wvalid;
  logic [DATA_W-1:0]       m_wdata;
  logic [STRB_W-1:0]       m_wstrb;
  logic                    m_wready;
  logic                    m_bvalid;
  logic [1:0]              m_bresp;
  logic                    m_bready;

  logic [N_MST-1:0]        arb_req_o;
  logic [N_MST-1:0]        arb_grant_i;
  logic                    arb_ack_o;

  // The mux itself: a slave towards the masters, forwarding to the real slave.
  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_awready, m_wready, m_bvalid, m_bresp,
    output arb_req_o, arb_ack_o,
    input  arb_grant_i
  );

  // Environment view: the masters, the downstream slave and the arbiter.
  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_awready, m_wready, m_bvalid, m_bresp,
    input  arb_req_o, arb_ack_o,
    output arb_grant_i
  );
endinterface

// File: rtl/axil_wr_slave_mux.sv
// AXI4-Lite write-path mux for one crossbar slave port: locks the arbiter's winner
// for a full AW/W/B transaction and acknowledges the arbiter on B completion.
module axil_wr_slave_mux #(
  parameter int N_MST  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  axil_wr_slave_mux_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_MST > 1) ? $clog2(N_MST) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_MST-1:0] sel_q, sel_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;

  logic [IDX_W-1:0] k;
  logic             aw_act, w_act;
  logic             aw_hs, w_hs, b_hs;

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [N_MST-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  assign k      = onehot_idx(sel_q);
  assign aw_act = (state_q == XFER) && !aw_done_q;
  assign w_act  = (state_q == XFER) && !w_done_q;
  assign aw_hs  = aw_act && bus.s_awvalid[k] && bus.m_awready;
  assign w_hs   = w_act && bus.s_wvalid[k] && bus.m_wready;
  assign b_hs   = (state_q == RESP) && bus.m_bvalid && bus.s_bready[k];

  // Channel routing; valids come only from master valids and state.
  always_comb begin
    bus.s_awready = '0;
    bus.s_wready  = '0;
    bus.s_bvalid  = '0;
    bus.s_bresp   = bus.m_bresp;
    bus.m_awvalid = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.m_bready  = 1'b0;
    bus.m_awaddr  = bus.s_awaddr[int'(k)*ADDR_W +: ADDR_W];
    bus.m_wdata   = bus.s_wdata[int'(k)*DATA_W +: DATA_W];
    bus.m_wstrb   = bus.s_wstrb[int'(k)*STRB_W +: STRB_W];
    bus.arb_req_o = (state_q == IDLE) ? bus.s_awvalid : sel_q;
    bus.arb_ack_o = b_hs;

    if (aw_act) begin
      bus.m_awvalid = bus.s_awvalid[k];
      bus.s_awready = sel_q & {N_MST{bus.m_awready}};
    end
    if (w_act) begin
      bus.m_wvalid = bus.s_wvalid[k];
      bus.s_wready = sel_q & {N_MST{bus.m_wready}};
    end
    if (state_q == RESP) begin
      bus.s_bvalid = sel_q & {N_MST{bus.m_bvalid}};
      bus.m_bready = bus.s_bready[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        // A zero grant with pending requests is an arbiter fault: wait it out.
        if ((|bus.s_awvalid) && (|bus.arb_grant_i)) begin
          sel_d   = bus.arb_grant_i;
          state_d = XFER;
        end
      end
      XFER: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RESP: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axil_wr_slave_mux.sv
// Scoreboard bench for axil_wr_slave_mux: directed transactions push expected
// AW/W/B results; a monitor pops and compares on every handshake.
`timescale 1ns/100ps
module tb_axil_wr_slave_mux;
  localparam int N_MST  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef struct {
    int         idx;
    logic [1:0] resp;
  } b_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axil_wr_slave_mux_if #(.N_MST(N_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_wr_slave_mux #(.N_MST(N_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Master, slave and arbiter models
  logic [N_MST-1:0]  aw_pend = '0, w_pend = '0, bready_en = '1;
  logic [ADDR_W-1:0] m_addr [N_MST];
  logic [DATA_W-1:0] m_data [N_MST];
  logic [STRB_W-1:0] m_strb [N_MST];
  logic              slv_aw_rdy = 1'b1, slv_w_rdy = 1'b1;
  logic              b_pend = 1'b0, got_aw = 1'b0, got_w = 1'b0;
  logic [1:0]        slv_bresp = 2'b00;
  int                ptr = 0;

  logic [ADDR_W-1:0]        exp_aw [$];
  logic [DATA_W+STRB_W-1:0] exp_w  [$];
  b_exp_t                   exp_b  [$];

  int n_chk = 0, n_pass = 0, ack_cnt = 0;

  function automatic logic [N_MST-1:0] rr_grant(input logic [N_MST-1:0] req, input int p);
    logic [N_MST-1:0] g;
    g = '0;
    for (int o = 0; o < N_MST; o++) begin
      int j;
      j = (p + o) % N_MST;
      if (g == '0 && req[j]) g[j] = 1'b1;
    end
    return g;
  endfunction

  function automatic int oh_idx(input logic [N_MST-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < N_MST; i++) if (oh[i]) r = i;
    return r;
  endfunction

  for (genvar g = 0; g < N_MST; g++) begin : g_pack
    assign bus.s_awaddr[g*ADDR_W +: ADDR_W] = m_addr[g];
    assign bus.s_wdata[g*DATA_W +: DATA_W]  = m_data[g];
    assign bus.s_wstrb[g*STRB_W +: STRB_W]  = m_strb[g];
  end
  assign bus.s_awvalid   = aw_pend;
  assign bus.s_wvalid    = w_pend;
  assign bus.s_bready    = bready_en;
  assign bus.m_awready   = slv_aw_rdy;
  assign bus.m_wready    = slv_w_rdy;
  assign bus.m_bvalid    = b_pend;
  assign bus.m_bresp     = slv_bresp;
  assign bus.arb_grant_i = rr_grant(bus.arb_req_o, ptr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic issue(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [STRB_W-1:0] s, input logic [1:0] resp);
    b_exp_t e;
    m_addr[i] = a;
    m_data[i] = d;
    m_strb[i] = s;
    aw_pend[i] = 1'b1;
    w_pend[i]  = 1'b1;
    exp_aw.push_back(a);
    exp_w.push_back({d, s});
    e.idx = i;
    e.resp = resp;
    exp_b.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_s_awready", bus.s_awready, 0);
    chk("rst_s_wready",  bus.s_wready, 0);
    chk("rst_s_bvalid",  bus.s_bvalid, 0);
    chk("rst_m_awvalid", bus.m_awvalid, 0);
    chk("rst_m_wvalid",  bus.m_wvalid, 0);
    chk("rst_m_bready",  bus.m_bready, 0);
    chk("rst_ack",       bus.arb_ack_o, 0);
    aw_pend = '0; w_pend = '0; bready_en = '1;
    slv_aw_rdy = 1'b1; slv_w_rdy = 1'b1; slv_bresp = 2'b00;
    b_pend = 1'b0; got_aw = 1'b0; got_w = 1'b0; ptr = 0;
    exp_aw.delete(); exp_w.delete(); exp_b.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      #1;
      if (exp_aw.size() == 0 && exp_w.size() == 0 && exp_b.size() == 0) done = 1;
    end
    n_chk++;
    if (done) n_pass++;
    else $display("FAIL wait_done: %0d AW / %0d W / %0d B still outstanding, want 0",
                  exp_aw.size(), exp_w.size(), exp_b.size());
  endtask

  // Environment: handshakes seen at negedge complete at the next posedge.
  initial begin : env
    logic [N_MST-1:0] hs_aw, hs_w, win;
    logic sv_aw, sv_w, sv_b, ack_seen;
    forever begin
      @(negedge clk);
      hs_aw    = rst_n ? (bus.s_awvalid & bus.s_awready) : '0;
      hs_w     = rst_n ? (bus.s_wvalid & bus.s_wready) : '0;
      sv_aw    = rst_n && bus.m_awvalid && bus.m_awready;
      sv_w     = rst_n && bus.m_wvalid && bus.m_wready;
      sv_b     = rst_n && bus.m_bvalid && bus.m_bready;
      ack_seen = rst_n && bus.arb_ack_o;
      win      = bus.arb_req_o;
      @(posedge clk);
      #1;
      if (rst_n) begin
        aw_pend = aw_pend & ~hs_aw;
        w_pend  = w_pend & ~hs_w;
        if (sv_aw) got_aw = 1'b1;
        if (sv_w)  got_w  = 1'b1;
        if (sv_b)  b_pend = 1'b0;
        if (got_aw && got_w) begin
          b_pend = 1'b1;
          got_aw = 1'b0;
          got_w  = 1'b0;
        end
        if (ack_seen) ptr = (oh_idx(win) + 1) % N_MST;
      end
    end
  end

  // Monitor / scoreboard
  initial begin : mon
    logic [N_MST-1:0] busy, bhs;
    b_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        busy = bus.s_awready | bus.s_wready | bus.s_bvalid;
        if (exp_b.size() > 0)
          chk("non_winner_quiet", busy & ~(N_MST'(1) << exp_b[0].idx), 0);
        else if (busy != '0)
          chk("idle_quiet", busy, 0);
        if (bus.m_awvalid && bus.m_awready) begin
          if (exp_aw.size() == 0) begin
            n_chk++;
            $display("FAIL aw_unexpected: got addr 0x%0h, want no AW handshake", bus.m_awaddr);
          end else chk("m_awaddr", bus.m_awaddr, exp_aw.pop_front());
        end
        if (bus.m_wvalid && bus.m_wready) begin
          if (exp_w.size() == 0) begin
            n_chk++;
            $display("FAIL w_unexpected: got data 0x%0h, want no W handshake", bus.m_wdata);
          end else chk("m_wdata_wstrb", {bus.m_wdata, bus.m_wstrb}, exp_w.pop_front());
        end
        bhs = bus.s_bvalid & bus.s_bready;
        if (bhs != '0 || bus.arb_ack_o) chk("ack_on_b", bus.arb_ack_o, (bhs != '0));
        if (bus.arb_ack_o) ack_cnt++;
        if (bhs != '0) begin
          if (exp_b.size() == 0) begin
            n_chk++;
            $display("FAIL b_unexpected: got bvalid&bready 0x%0h, want none", bhs);
          end else begin
            e = exp_b.pop_front();
            chk("b_master", bhs, N_MST'(1) << e.idx);
            chk("b_resp", bus.s_bresp, e.resp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0;
    #3;
    // Single master
    do_reset();
    a0 = ack_cnt;
    @(posedge clk); #2 issue(1, 32'h100, 32'hDEADBEEF, 4'hF, 2'b00);
    @(negedge clk); chk("t1_req_idle", bus.arb_req_o, 4'b0010);
    @(negedge clk);
    chk("t1_awvalid", bus.m_awvalid, 1);
    chk("t1_awaddr",  bus.m_awaddr, 32'h100);
    chk("t1_wdata",   bus.m_wdata, 32'hDEADBEEF);
    chk("t1_req_lock", bus.arb_req_o, 4'b0010);
    @(negedge clk); chk("t1_bvalid", bus.s_bvalid, 4'b0010);
    wait_done(20);
    repeat (3) @(negedge clk);
    chk("t1_ack_count", ack_cnt - a0, 1);

    // Contention: masters 0 and 2
    do_reset();
    @(posedge clk); #2;
    issue(0, 32'h200, 32'h11111111, 4'h3, 2'b00);
    issue(2, 32'h300, 32'h22222222, 4'hC, 2'b00);
    @(negedge clk); chk("t2_req_both", bus.arb_req_o, 4'b0101);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t2_m2_awready", bus.s_awready[2], 0);
      if (bus.s_bvalid[0] && bus.s_bready[0]) break;
    end
    @(negedge clk); chk("t2_req_after", bus.arb_req_o, 4'b0100);
    wait_done(20);

    // W before AW
    do_reset();
    @(posedge clk); #2;
    slv_aw_rdy = 1'b0;
    issue(3, 32'h400, 32'hCAFEF00D, 4'hF, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("t3_w_hs_c1", bus.m_wvalid & bus.m_wready, 1);
    chk("t3_awvalid_c1", bus.m_awvalid, 1);
    @(negedge clk); chk("t3_no_w_c2", bus.m_wvalid, 0);
    @(negedge clk); chk("t3_no_w_c3", bus.m_wvalid | bus.s_wready[3], 0);
    @(posedge clk); #2 slv_aw_rdy = 1'b1;
    @(negedge clk);
    chk("t3_aw_hs_c4", bus.m_awvalid & bus.m_awready, 1);
    chk("t3_no_w_c4", bus.m_wvalid, 0);
    @(negedge clk); chk("t3_resp_c5", bus.s_bvalid, 4'b1000);
    wait_done(20);

    // Slave B backpressure
    do_reset();
    @(posedge clk); #2;
    bready_en[1] = 1'b0;
    slv_bresp = 2'b10;
    issue(1, 32'h500, 32'h0BADF00D, 4'h5, 2'b10);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_m_bvalid", bus.m_bvalid, 1);
      chk("t4_m_bready", bus.m_bready, 0);
      chk("t4_s_bvalid", bus.s_bvalid, 4'b0010);
      chk("t4_ack_low", bus.arb_ack_o, 0);
    end
    @(posedge clk); #2 bready_en[1] = 1'b1;
    @(negedge clk);
    chk("t4_ack_pulse", bus.arb_ack_o, 1);
    chk("t4_m_bready_hi", bus.m_bready, 1);
    @(negedge clk);
    chk("t4_idle_req", bus.arb_req_o, 4'b0000);
    chk("t4_idle_bvalid", bus.s_bvalid, 4'b0000);
    wait_done(20);

    // Reset mid-transaction
    do_reset();
    @(posedge clk); #2;
    slv_w_rdy = 1'b0;
    issue(2, 32'h600, 32'h12345678, 4'hF, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("t5_aw_hs", bus.m_awvalid & bus.m_awready, 1);
    chk("t5_wvalid", bus.m_wvalid, 1);
    @(posedge clk); #2;
    a0 = ack_cnt;
    do_reset();
    chk("t5_no_ack", ack_cnt - a0, 0);
    a0 = ack_cnt;
    @(posedge clk); #2 issue(2, 32'h700, 32'h87654321, 4'hA, 2'b00);
    wait_done(20);
    repeat (2) @(negedge clk);
    chk("t5_clean_ack", ack_cnt - a0, 1);

    // Back-to-back, all four masters
    do_reset();
    a0 = ack_cnt;
    @(posedge clk); #2;
    issue(0, 32'h1000, 32'hA0A0A0A0, 4'h1, 2'b00);
    issue(1, 32'h1004, 32'hB1B1B1B1, 4'h2, 2'b00);
    issue(2, 32'h1008, 32'hC2C2C2C2, 4'h4, 2'b00);
    issue(3, 32'h100C, 32'hD3D3D3D3, 4'h8, 2'b00);
    @(negedge clk); chk("t6_req_all", bus.arb_req_o, 4'b1111);
    wait_done(60);
    repeat (2) @(negedge clk);
    chk("t6_ack_count", ack_cnt - a0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
